neuron_mac: RTL

Upstream neighbour of the sigmoid activation stage. It accumulates N_INPUTS signed Q8.8 input×weight products plus a bias for one neuron, then saturates the result to Q8.8. The saturated sum is presented on a valid/ready output whose data connects directly to the sigmoid `sig_in`. Each neuron evaluation is one accumulation frame; frames are processed back-to-back.

---
 rtl/neuron_mac.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Brief    : Q8.8 multiply-accumulate of one neuron frame plus bias, saturated
//            to Q8.8 and presented on a valid/ready output (feeds sigmoid).
// Revision : 1.0  initial release
// ============================================================================
module neuron_mac #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  input  logic [15:0] w_in,
  input  logic [15:0] bias,
  output logic [15:0] sum_out,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic        busy
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0]        c_last    = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] c_pos_lim = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] c_neg_lim = -c_pos_lim;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_FLUSH = 3'd2,
    S_SAT   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [31:0]       r_prod;
  logic                     r_prod_v;
  logic [CNT_W-1:0]         r_cnt;
  logic [15:0]              r_sum_out;
  logic                     r_sum_valid;

  logic                     w_accept;
  logic signed [31:0]       w_x;
  logic signed [31:0]       w_w;
  logic signed [31:0]       w_mul;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic [15:0]              w_sat;

  assign w_accept   = in_valid & in_ready;
  assign w_x        = {{16{x_in[15]}}, x_in};
  assign w_w        = {{16{w_in[15]}}, w_in};
  assign w_mul      = w_x * w_w;
  assign w_prod_ext = {{(ACC_W-32){r_prod[31]}}, r_prod};
  // Q8.8 bias aligned to the Q.16 accumulator fraction
  assign w_bias_ext = {{(ACC_W-24){bias[15]}}, bias, 8'h00};
  assign w_shift    = r_acc >>> 8;

  // Clamp to +/-0x7FFF so 0x8000 is never emitted
  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > c_pos_lim)
      w_sat = 16'h7FFF;
    else if (w_shift < c_neg_lim)
      w_sat = 16'h8001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_next = (N_INPUTS == 1) ? S_FLUSH : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == c_last))
          w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_SAT;
      S_SAT:   w_next = S_OUT;
      S_OUT: begin
        if (sum_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
      r_cnt       <= '0;
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= w_bias_ext;
            r_prod   <= w_mul;
            r_prod_v <= 1'b1;
            r_cnt    <= CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (r_prod_v)
            r_acc <= r_acc + w_prod_ext;
          if (w_accept) begin
            r_prod   <= w_mul;
            r_prod_v <= 1'b1;
            r_cnt    <= r_cnt + 1'b1;
          end else begin
            r_prod_v <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_prod_v)
            r_acc <= r_acc + w_prod_ext;
          r_prod_v <= 1'b0;
        end
        S_SAT: begin
          r_sum_out   <= w_sat;
          r_sum_valid <= 1'b1;
        end
        S_OUT: begin
          if (sum_ready)
            r_sum_valid <= 1'b0;
        end
        default: r_prod_v <= 1'b0;
      endcase
    end
  end

  assign sum_out   = r_sum_out;
  assign sum_valid = r_sum_valid;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
